multicycle_ctrl_fsm: RTL and testbench

Sequencing control unit for the multi-cycle RISC datapath. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB states, holds on instruction- and data-memory ready handshakes, and drives per-cycle datapath strobes. It also decodes the 2-bit instruction type and OPCODE_W-bit opcode into the datapath control bundle, flags illegal encodings and counts retired instructions. It sits between the instruction register and the datapath, replacing the purely combinational decoder.

---
 rtl/multicycle_ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB walk, instruction decode, retire count.
// Optional shift decode is enabled by defining CTRL_SHIFT_EN.
module multicycle_ctrl_fsm #(
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          instr_type,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                alu_zero,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_b,
  output logic                reg_wr,
  output logic                link,
  output logic                ext_op,
  output logic [1:0]          alu_src,
  output logic [2:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                wb_src,
  output logic                illegal,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_AND, C_ADD, C_SUB, C_CMP, C_ANDI, C_ADDI, C_LW,
    C_SW, C_BEQ, C_J, C_JAL, C_SLL, C_SLR, C_SLLV, C_SLRV
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic             run_q;
  logic [CNT_W-1:0] ret_q;
  logic             ret_inc;
  logic [2:0]       aop_c;
  logic [1:0]       asrc_c;
  logic             ext_c, regb_c;

  always_comb begin
    dec_cls = C_ILL;
    case (instr_type)
      2'b00: case (opcode)
        OPCODE_W'(0): dec_cls = C_AND;
        OPCODE_W'(1): dec_cls = C_ADD;
        OPCODE_W'(2): dec_cls = C_SUB;
        OPCODE_W'(3): dec_cls = C_CMP;
        default:      dec_cls = C_ILL;
      endcase
      2'b01: case (opcode)
        OPCODE_W'(0): dec_cls = C_ANDI;
        OPCODE_W'(1): dec_cls = C_ADDI;
        OPCODE_W'(2): dec_cls = C_LW;
        OPCODE_W'(3): dec_cls = C_SW;
        OPCODE_W'(4): dec_cls = C_BEQ;
        default:      dec_cls = C_ILL;
      endcase
      2'b10: case (opcode)
        OPCODE_W'(0): dec_cls = C_J;
        OPCODE_W'(1): dec_cls = C_JAL;
        default:      dec_cls = C_ILL;
      endcase
`ifdef CTRL_SHIFT_EN
      2'b11: case (opcode)
        OPCODE_W'(0): dec_cls = C_SLL;
        OPCODE_W'(1): dec_cls = C_SLR;
        OPCODE_W'(2): dec_cls = C_SLLV;
        OPCODE_W'(3): dec_cls = C_SLRV;
        default:      dec_cls = C_ILL;
      endcase
`endif
      default: dec_cls = C_ILL;
    endcase
  end

  // ALU bundle is a Moore function of the held class, stable from EXEC through WB
  always_comb begin
    aop_c  = 3'b000;
    asrc_c = 2'b00;
    ext_c  = 1'b0;
    regb_c = 1'b0;
    case (cls_q)
      C_ADD:       aop_c = 3'b001;
      C_SUB:       aop_c = 3'b010;
      C_CMP:       aop_c = 3'b101;
      C_ANDI:      asrc_c = 2'b01;
      C_ADDI, C_LW: begin aop_c = 3'b001; asrc_c = 2'b01; ext_c = 1'b1; end
      C_SW:        begin aop_c = 3'b001; asrc_c = 2'b01; ext_c = 1'b1; regb_c = 1'b1; end
      C_BEQ:       begin aop_c = 3'b010; ext_c = 1'b1; regb_c = 1'b1; end
`ifdef CTRL_SHIFT_EN
      C_SLL:       begin aop_c = 3'b011; asrc_c = 2'b10; end
      C_SLR:       begin aop_c = 3'b100; asrc_c = 2'b10; end
      C_SLLV:      aop_c = 3'b011;
      C_SLRV:      aop_c = 3'b100;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    ret_inc   = 1'b0;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_b     = 1'b0;
    reg_wr    = 1'b0;
    link      = 1'b0;
    ext_op    = 1'b0;
    alu_src   = 2'b00;
    alu_op    = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_src    = 1'b0;
    illegal   = 1'b0;
    // run_q holds everything quiet until the first edge after reset release
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          case (dec_cls)
            C_ILL: begin illegal = 1'b1; state_d = S_FETCH; end
            C_J, C_JAL: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
              reg_wr   = (dec_cls == C_JAL);
              link     = (dec_cls == C_JAL);
              ret_inc  = 1'b1;
              state_d  = S_FETCH;
            end
            default: begin cls_d = dec_cls; state_d = S_EXEC; end
          endcase
        end
        S_EXEC, S_MEM, S_WB: begin
          alu_op  = aop_c;
          alu_src = asrc_c;
          ext_op  = ext_c;
          reg_b   = regb_c;
          if (state_q == S_EXEC) begin
            if (cls_q == C_BEQ) begin
              pc_write = alu_zero;
              pc_src   = alu_zero ? 2'b01 : 2'b00;
              ret_inc  = 1'b1;
              state_d  = S_FETCH;
            end else if (cls_q == C_LW || cls_q == C_SW) begin
              state_d = S_MEM;
            end else begin
              state_d = S_WB;
            end
          end else if (state_q == S_MEM) begin
            mem_read  = (cls_q == C_LW);
            mem_write = (cls_q == C_SW);
            if (dmem_ready) begin
              ret_inc = (cls_q == C_SW);
              state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
            end
          end else begin
            reg_wr  = 1'b1;
            wb_src  = (cls_q == C_LW);
            ret_inc = 1'b1;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
    if (state_d == S_FETCH) cls_d = C_ILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      run_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      cls_q   <= cls_d;
      if (ret_inc) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected outputs from a class-level model.
module tb_multicycle_ctrl_fsm;
  localparam int OW = 5;
  localparam int CW = 4;
`ifdef CTRL_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] instr_type;
  logic [OW-1:0] opcode;
  logic imem_ready, dmem_ready, alu_zero;
  logic imem_req, ir_write, pc_write, reg_b, reg_wr, link, ext_op;
  logic mem_read, mem_write, wb_src, illegal;
  logic [1:0] pc_src, alu_src;
  logic [2:0] alu_op, state;
  logic [CW-1:0] retired;

  multicycle_ctrl_fsm #(.OPCODE_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_type(instr_type), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_b(reg_b), .reg_wr(reg_wr), .link(link), .ext_op(ext_op), .alu_src(alu_src),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .wb_src(wb_src),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic imem_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic reg_b, reg_wr, link, ext_op;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
    logic mem_read, mem_write, wb_src, illegal;
    logic [CW-1:0] ret;
  } obs_t;

  typedef struct packed {
    logic [1:0] t;
    logic [OW-1:0] op;
    logic ir, dr, z;
  } inp_t;

  typedef struct packed {
    logic legal, jmp, jal, beq, lw, sw, regb, ext;
    logic [2:0] aop;
    logic [1:0] asrc;
  } dec_t;

  typedef struct {
    obs_t  o;
    string nm;
    int    cyc;
  } sb_t;

  sb_t  sbq[$];
  int   total = 0;
  int   bad = 0;
  int   mret = 0;
  sb_t  mon_e;
  obs_t mon_a;

  function automatic obs_t cur();
    obs_t a;
    a.st = state; a.imem_req = imem_req; a.ir_write = ir_write; a.pc_write = pc_write;
    a.pc_src = pc_src; a.reg_b = reg_b; a.reg_wr = reg_wr; a.link = link; a.ext_op = ext_op;
    a.alu_src = alu_src; a.alu_op = alu_op; a.mem_read = mem_read; a.mem_write = mem_write;
    a.wb_src = wb_src; a.illegal = illegal; a.ret = retired;
    return a;
  endfunction

  // Instruction table: legality, flow kind and the EXEC ALU bundle of each encoding
  function automatic dec_t decode(logic [1:0] t, int op);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (t)
      2'd0: case (op)
        0: d.aop = 3'd0;
        1: d.aop = 3'd1;
        2: d.aop = 3'd2;
        3: d.aop = 3'd5;
        default: d.legal = 1'b0;
      endcase
      2'd1: begin
        d.asrc = 2'd1;
        d.ext = (op != 0);
        case (op)
          0: d.aop = 3'd0;
          1: d.aop = 3'd1;
          2: begin d.aop = 3'd1; d.lw = 1'b1; end
          3: begin d.aop = 3'd1; d.sw = 1'b1; d.regb = 1'b1; end
          4: begin d.aop = 3'd2; d.asrc = 2'd0; d.beq = 1'b1; d.regb = 1'b1; end
          default: d.legal = 1'b0;
        endcase
      end
      2'd2: case (op)
        0: d.jmp = 1'b1;
        1: begin d.jmp = 1'b1; d.jal = 1'b1; end
        default: d.legal = 1'b0;
      endcase
      default: begin
        if (!SHIFT_EN || op > 3) d.legal = 1'b0;
        else begin
          d.aop  = op[0] ? 3'd4 : 3'd3;
          d.asrc = op[1] ? 2'd0 : 2'd2;
        end
      end
    endcase
    return d;
  endfunction

  function automatic obs_t alu(obs_t o, dec_t d);
    obs_t r;
    r = o;
    r.alu_op = d.aop; r.alu_src = d.asrc; r.ext_op = d.ext; r.reg_b = d.regb;
    return r;
  endfunction

  function automatic inp_t rnd_in();
    inp_t x;
    x.t = 2'($urandom_range(0, 3));
    x.op = OW'($urandom);
    x.ir = 1'($urandom_range(0, 1));
    x.dr = 1'($urandom_range(0, 1));
    x.z = 1'($urandom_range(0, 1));
    return x;
  endfunction

  task automatic drive(input inp_t x);
    instr_type = x.t; opcode = x.op; imem_ready = x.ir; dmem_ready = x.dr; alu_zero = x.z;
  endtask

  task automatic chk_zero(input string nm);
    obs_t a;
    a = cur();
    total++;
    if (a !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", nm, a);
    end
  endtask

  // Called at a posedge; returns at the posedge that starts the next instruction
  task automatic run_instr(input logic [1:0] t, input int op, input int iw, input int dw,
                           input bit z, input int abort, input string nm);
    dec_t d;
    obs_t q[$];
    inp_t in[$];
    obs_t o, b;
    inp_t x;
    int n;
    d = decode(t, op);
    b = '0;
    b.ret = CW'(mret);
    for (int w = 0; w < iw; w++) begin
      o = b; o.imem_req = 1'b1; q.push_back(o);
      x = rnd_in(); x.ir = 1'b0; in.push_back(x);
    end
    o = b; o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1; q.push_back(o);
    x = rnd_in(); x.ir = 1'b1; in.push_back(x);
    o = b; o.st = 3'd1;
    x = rnd_in(); x.t = t; x.op = OW'(op);
    if (!d.legal) o.illegal = 1'b1;
    else if (d.jmp) begin
      o.pc_write = 1'b1; o.pc_src = 2'b10; o.reg_wr = d.jal; o.link = d.jal;
    end
    q.push_back(o); in.push_back(x);
    if (d.legal && !d.jmp) begin
      o = alu(b, d); o.st = 3'd2; x = rnd_in();
      if (d.beq) begin
        x.z = z; o.pc_write = z; o.pc_src = z ? 2'b01 : 2'b00;
      end
      q.push_back(o); in.push_back(x);
      if (d.lw || d.sw) begin
        for (int k = 0; k <= dw; k++) begin
          o = alu(b, d); o.st = 3'd3; o.mem_read = d.lw; o.mem_write = d.sw;
          x = rnd_in(); x.dr = (k == dw);
          q.push_back(o); in.push_back(x);
        end
      end
      if (!d.beq && !d.sw) begin
        o = alu(b, d); o.st = 3'd4; o.reg_wr = 1'b1; o.wb_src = d.lw;
        q.push_back(o); in.push_back(rnd_in());
      end
    end
    n = q.size();
    if (abort > 0 && abort < n) n = abort;
    for (int i = 0; i < n; i++) sbq.push_back('{q[i], nm, i});
    for (int i = 0; i < n; i++) begin
      #1 drive(in[i]);
      @(posedge clk);
    end
    if (d.legal && n == q.size()) mret++;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      mon_a = cur();
      total++;
      if (mon_a !== mon_e.o) begin
        bad++;
        $display("FAIL %s[%0d] got=%h want=%h", mon_e.nm, mon_e.cyc, mon_a, mon_e.o);
      end
    end
  end

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_zero("idle_after_release");
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0);
    #2 chk_zero("reset");
    imem_ready = 1'b1; dmem_ready = 1'b1; instr_type = 2'd2;
    @(negedge clk) chk_zero("reset_inputs_high");
    release_reset();

    run_instr(2'd0, 1, 0, 0, 1'b0, 0, "ADD");
    run_instr(2'd1, 2, 0, 3, 1'b0, 0, "LW_slow");
    run_instr(2'd1, 4, 0, 0, 1'b1, 0, "BEQ_taken");
    run_instr(2'd1, 4, 0, 0, 1'b0, 0, "BEQ_not");
    run_instr(2'd2, 1, 0, 0, 1'b0, 0, "JAL");
    run_instr(2'd2, 0, 2, 0, 1'b0, 0, "J_slowfetch");
    run_instr(2'd1, 7, 0, 0, 1'b0, 0, "ILL_I7");
    run_instr(2'd3, 0, 0, 0, 1'b0, 0, "SLL");
    run_instr(2'd3, 3, 0, 0, 1'b0, 0, "SLRV");
    run_instr(2'd0, 3, 1, 0, 1'b0, 0, "CMP");
    run_instr(2'd1, 3, 0, 2, 1'b0, 0, "SW");
    run_instr(2'd1, 0, 0, 0, 1'b0, 0, "ANDI");
    run_instr(2'd0, 9, 0, 0, 1'b0, 0, "ILL_R9");
    run_instr(2'd2, 2, 0, 0, 1'b0, 0, "ILL_J2");

    for (int i = 0; i < 400; i++) begin
      int op;
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      run_instr(2'($urandom_range(0, 3)), op, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, "rand");
    end

    // LW caught in MEM waiting on data memory, then reset mid-instruction
    run_instr(2'd1, 2, 1, 6, 1'b0, 6, "LW_abort");
    #1 begin
      inp_t x;
      x = rnd_in(); x.dr = 1'b0; drive(x);
    end
    @(negedge clk);
    #1;
    total++;
    if (mem_read !== 1'b1 || state !== 3'd3) begin
      bad++;
      $display("FAIL abort_pre got mem_read=%b state=%0d want mem_read=1 state=3", mem_read, state);
    end
    rst_n = 1'b0;
    #1 chk_zero("reset_mid_mem");
    mret = 0;
    release_reset();
    run_instr(2'd0, 1, 0, 0, 1'b0, 0, "ADD_post");
    for (int i = 0; i < 20; i++)
      run_instr(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0, "rand_post");
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
